// File: rtl/subpel_pkg.sv
// Shared constants, candidate indices and FSM states for the sub-pel SAD
// accumulate-and-select block.
package subpel_pkg;

   localparam int unsigned NCAND      = 25;
   localparam int unsigned LINES      = 6;
   localparam int unsigned LANES      = 6;
   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned LANE_BUS_W = LANES * BYTE_W;
   localparam int unsigned DIFF_W     = NCAND * LANE_BUS_W;
   localparam int unsigned LINE_SUM_W = 11;
   localparam int unsigned SAD_W      = 14;
   localparam int unsigned IDX_W      = 5;
   localparam int unsigned CNT_W      = 3;

   // k = 5*row + col; rows UH,UQ,M,LQ,LH; cols h,q,f,r,i
   localparam int unsigned CAND_UH_H = 0;
   localparam int unsigned CAND_UH_Q = 1;
   localparam int unsigned CAND_UH_F = 2;
   localparam int unsigned CAND_UH_R = 3;
   localparam int unsigned CAND_UH_I = 4;
   localparam int unsigned CAND_UQ_H = 5;
   localparam int unsigned CAND_UQ_Q = 6;
   localparam int unsigned CAND_UQ_F = 7;
   localparam int unsigned CAND_UQ_R = 8;
   localparam int unsigned CAND_UQ_I = 9;
   localparam int unsigned CAND_M_H  = 10;
   localparam int unsigned CAND_M_Q  = 11;
   localparam int unsigned CAND_M_F  = 12;
   localparam int unsigned CAND_M_R  = 13;
   localparam int unsigned CAND_M_I  = 14;
   localparam int unsigned CAND_LQ_H = 15;
   localparam int unsigned CAND_LQ_Q = 16;
   localparam int unsigned CAND_LQ_F = 17;
   localparam int unsigned CAND_LQ_R = 18;
   localparam int unsigned CAND_LQ_I = 19;
   localparam int unsigned CAND_LH_H = 20;
   localparam int unsigned CAND_LH_Q = 21;
   localparam int unsigned CAND_LH_F = 22;
   localparam int unsigned CAND_LH_R = 23;
   localparam int unsigned CAND_LH_I = 24;

   typedef enum logic {
      ACCUM  = 1'b0,
      SEARCH = 1'b1
   } state_e;

endpackage

// File: rtl/row_sum6.sv
// Sum of six 8-bit absolute differences packed in a 48-bit lane bus.
module row_sum6
   import subpel_pkg::*;
(
   input  logic [LANE_BUS_W-1:0] lanes,
   output logic [LINE_SUM_W-1:0] sum_c
);

   always_comb begin
      sum_c = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         sum_c = sum_c + LINE_SUM_W'(lanes[i*BYTE_W +: BYTE_W]);
      end
   end

endmodule

// File: rtl/subpel_sad_select.sv
// Accumulates six lines of per-candidate abs-diff sums, then scans the 25
// accumulators one per cycle and reports the minimum-SAD candidate.
module subpel_sad_select
   import subpel_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DIFF_W-1:0] diff_in,
   input  logic              abort,
   output logic              out_valid,
   output logic [IDX_W-1:0]  best_idx,
   output logic [SAD_W-1:0]  best_sad
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
   logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
   logic [SAD_W-1:0]     acc_q [NCAND];
   logic [SAD_W-1:0]     acc_d [NCAND];
   logic [SAD_W-1:0]     srch_sad_q, srch_sad_d;
   logic [IDX_W-1:0]     srch_idx_q, srch_idx_d;
   logic                 out_valid_q, out_valid_d;
   logic [IDX_W-1:0]     best_idx_q, best_idx_d;
   logic [SAD_W-1:0]     best_sad_q, best_sad_d;

   logic [LINE_SUM_W-1:0] line_sum [NCAND];
   logic                  accept;
   logic [SAD_W-1:0]      cand_sad, ref_sad, win_sad;
   logic [IDX_W-1:0]      ref_idx, win_idx;

   for (genvar g = 0; g < int'(NCAND); g++) begin : g_row
      row_sum6 u_row_sum6 (
         .lanes (diff_in[g*LANE_BUS_W +: LANE_BUS_W]),
         .sum_c (line_sum[g])
      );
   end

   // Abort suppresses acceptance in the same cycle, so it also drops in_ready.
   assign in_ready = (state_q == ACCUM) && !rst && !abort;
   assign accept   = in_valid && in_ready;

   // Scan compare: the centre seeds the running best, strict less-than wins.
   always_comb begin
      cand_sad = acc_q[scan_idx_q];
      ref_sad  = (scan_idx_q == '0) ? acc_q[CAND_M_F] : srch_sad_q;
      ref_idx  = (scan_idx_q == '0) ? IDX_W'(CAND_M_F) : srch_idx_q;
      if (cand_sad < ref_sad) begin
         win_sad = cand_sad;
         win_idx = scan_idx_q;
      end else begin
         win_sad = ref_sad;
         win_idx = ref_idx;
      end
   end

   always_comb begin
      state_d     = state_q;
      line_cnt_d  = line_cnt_q;
      scan_idx_d  = scan_idx_q;
      srch_sad_d  = srch_sad_q;
      srch_idx_d  = srch_idx_q;
      out_valid_d = 1'b0;
      best_idx_d  = best_idx_q;
      best_sad_d  = best_sad_q;
      for (int k = 0; k < int'(NCAND); k++) begin
         acc_d[k] = acc_q[k];
      end

      case (state_q)
         ACCUM: begin
            if (abort) begin
               line_cnt_d = '0;
            end else if (accept) begin
               // Line 0 loads, so no clear cycle is needed between blocks.
               for (int k = 0; k < int'(NCAND); k++) begin
                  acc_d[k] = (line_cnt_q == '0) ? SAD_W'(line_sum[k])
                                                : acc_q[k] + SAD_W'(line_sum[k]);
               end
               if (line_cnt_q == CNT_W'(LINES - 1)) begin
                  line_cnt_d = '0;
                  scan_idx_d = '0;
                  state_d    = SEARCH;
               end else begin
                  line_cnt_d = line_cnt_q + CNT_W'(1);
               end
            end
         end
         SEARCH: begin
            if (abort) begin
               state_d    = ACCUM;
               scan_idx_d = '0;
               line_cnt_d = '0;
            end else begin
               srch_sad_d = win_sad;
               srch_idx_d = win_idx;
               if (scan_idx_q == IDX_W'(NCAND - 1)) begin
                  state_d     = ACCUM;
                  scan_idx_d  = '0;
                  out_valid_d = 1'b1;
                  best_idx_d  = win_idx;
                  best_sad_d  = win_sad;
               end else begin
                  scan_idx_d = scan_idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ACCUM;
         line_cnt_q  <= '0;
         scan_idx_q  <= '0;
         srch_sad_q  <= '0;
         srch_idx_q  <= '0;
         out_valid_q <= 1'b0;
         best_idx_q  <= '0;
         best_sad_q  <= '0;
         for (int k = 0; k < int'(NCAND); k++) begin
            acc_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         line_cnt_q  <= line_cnt_d;
         scan_idx_q  <= scan_idx_d;
         srch_sad_q  <= srch_sad_d;
         srch_idx_q  <= srch_idx_d;
         out_valid_q <= out_valid_d;
         best_idx_q  <= best_idx_d;
         best_sad_q  <= best_sad_d;
         for (int k = 0; k < int'(NCAND); k++) begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign best_idx  = best_idx_q;
   assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_subpel_sad_select.sv
// Directed bench for subpel_sad_select with a per-cycle reference model of
// block sums, minimum selection and result timing.
module tb_subpel_sad_select;
   import subpel_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DIFF_W-1:0] diff_in;
   logic              abort;
   logic              out_valid;
   logic [IDX_W-1:0]  best_idx;
   logic [SAD_W-1:0]  best_sad;

   subpel_sad_select dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .diff_in   (diff_in),
      .abort     (abort),
      .out_valid (out_valid),
      .best_idx  (best_idx),
      .best_sad  (best_sad)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model state
   bit chk_en = 0;
   int cyc = 0;
   int m_lines = 0;
   int m_due = -1;
   int m_ready_cyc = 0;
   int m_sum [NCAND];
   int m_last [NCAND];
   int m_res_idx = 0, m_res_sad = 0;
   int m_held_idx = 0, m_held_sad = 0;
   int ov_count = 0;
   int low_run = 0, last_low_run = 0;

   always @(negedge clk) begin
      bit exp_ready;
      int ls, minv;
      cyc++;
      if (chk_en) begin
         exp_ready = !rst && !abort && (cyc >= m_ready_cyc);
         if (cyc == m_due) begin
            m_held_idx = m_res_idx;
            m_held_sad = m_res_sad;
         end
         chk("out_valid", 32'(out_valid), 32'(cyc == m_due));
         chk("in_ready", 32'(in_ready), 32'(exp_ready));
         chk("best_idx", 32'(best_idx), 32'(m_held_idx));
         chk("best_sad", 32'(best_sad), 32'(m_held_sad));
         if (out_valid === 1'b1) ov_count++;
         if (in_ready !== 1'b1) low_run++;
         else begin
            if (low_run > 0) last_low_run = low_run;
            low_run = 0;
         end

         if (rst) begin
            m_lines = 0; m_due = -1; m_ready_cyc = cyc + 1;
            m_held_idx = 0; m_held_sad = 0;
         end else if (abort) begin
            m_lines = 0;
            if (cyc < m_ready_cyc) begin
               m_due = -1; m_ready_cyc = cyc + 1;
            end
         end else if (in_valid && exp_ready) begin
            for (int k = 0; k < int'(NCAND); k++) begin
               ls = 0;
               for (int i = 0; i < 6; i++) ls += int'(diff_in[k*48 + i*8 +: 8]);
               m_sum[k] = (m_lines == 0) ? ls : m_sum[k] + ls;
            end
            m_lines++;
            if (m_lines == int'(LINES)) begin
               // Smallest sum; centre wins ties, otherwise lowest index.
               minv = m_sum[0];
               for (int k = 1; k < int'(NCAND); k++) if (m_sum[k] < minv) minv = m_sum[k];
               if (m_sum[12] == minv) m_res_idx = 12;
               else begin
                  m_res_idx = -1;
                  for (int k = 0; k < int'(NCAND); k++)
                     if (m_res_idx < 0 && m_sum[k] == minv) m_res_idx = k;
               end
               m_res_sad = minv;
               for (int k = 0; k < int'(NCAND); k++) m_last[k] = m_sum[k];
               m_due = cyc + 26;
               m_ready_cyc = cyc + 26;
               m_lines = 0;
            end
         end
      end
   end

   // Stimulus helpers
   logic [7:0] lb [NCAND][6];

   function automatic logic [DIFF_W-1:0] pack_line();
      logic [DIFF_W-1:0] r;
      for (int k = 0; k < int'(NCAND); k++)
         for (int i = 0; i < 6; i++) r[k*48 + i*8 +: 8] = lb[k][i];
      return r;
   endfunction

   task automatic fill(input int v);
      for (int k = 0; k < int'(NCAND); k++)
         for (int i = 0; i < 6; i++) lb[k][i] = 8'(v);
   endtask

   task automatic set_cand(input int k, input int v);
      for (int i = 0; i < 6; i++) lb[k][i] = 8'(v);
   endtask

   task automatic send_line(input logic [DIFF_W-1:0] d);
      int guard;
      bit done;
      diff_in = d; in_valid = 1'b1; done = 0; guard = 0;
      while (!done) begin
         @(negedge clk);
         done = (in_ready === 1'b1);
         @(posedge clk); #1;
         guard++;
         if (!done && guard > 100) begin
            chk("send_timeout", 32'(0), 32'(1));
            done = 1;
         end
      end
   endtask

   task automatic send_block();
      for (int l = 0; l < int'(LINES); l++) send_line(pack_line());
   endtask

   task automatic wait_out(output int n);
      bit found;
      n = 0; found = 0;
      while (!found && n < 60) begin
         @(negedge clk);
         n++;
         if (out_valid === 1'b1) found = 1;
      end
      if (!found) chk("out_timeout", 32'(0), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, ov0;
      rst = 1'b1; in_valid = 1'b0; abort = 1'b0; diff_in = '0;
      @(posedge clk);
      chk_en = 1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;

      // All zeros: centre wins the tie at zero, result 26 cycles after line 6
      fill(0);
      send_block();
      in_valid = 1'b0;
      wait_out(n);
      chk("t1_latency", 32'(n), 32'(26));
      chk("t1_idx", 32'(best_idx), 32'(12));
      chk("t1_sad", 32'(best_sad), 32'(0));
      @(posedge clk); #1;

      // Saturated bytes except candidate 7
      fill(255); set_cand(7, 1);
      send_block();
      in_valid = 1'b0;
      wait_out(n);
      chk("t2_idx", 32'(best_idx), 32'(7));
      chk("t2_sad", 32'(best_sad), 32'(36));
      chk("t2_model_acc0", 32'(m_last[0]), 32'(9180));
      chk("t2_model_acc12", 32'(m_last[12]), 32'(9180));
      @(posedge clk); #1;

      // Candidates 3 and 20 tie at 60, others 100: lowest index wins
      for (int l = 0; l < int'(LINES); l++) begin
         fill(0);
         for (int k = 0; k < int'(NCAND); k++) lb[k][0] = (l < 4) ? 8'd17 : 8'd16;
         lb[3][0] = 8'd10; lb[20][0] = 8'd10;
         send_line(pack_line());
      end
      in_valid = 1'b0;
      wait_out(n);
      chk("t3_idx", 32'(best_idx), 32'(3));
      chk("t3_sad", 32'(best_sad), 32'(60));
      @(posedge clk); #1;

      // Two back-to-back blocks with in_valid held high throughout
      ov0 = ov_count;
      fill(9); set_cand(5, 1);
      send_block();
      fill(20); set_cand(18, 4);
      send_line(pack_line());
      chk("t4a_idx", 32'(best_idx), 32'(5));
      chk("t4a_sad", 32'(best_sad), 32'(36));
      for (int l = 1; l < int'(LINES); l++) send_line(pack_line());
      in_valid = 1'b0;
      wait_out(n);
      @(negedge clk);
      chk("t4b_idx", 32'(best_idx), 32'(18));
      chk("t4b_sad", 32'(best_sad), 32'(144));
      chk("t4_pulses", 32'(ov_count - ov0), 32'(2));
      chk("t4_ready_low", 32'(last_low_run), 32'(25));
      @(posedge clk); #1;

      // Abort after three lines, then a fresh block
      ov0 = ov_count;
      fill(3);
      for (int l = 0; l < 3; l++) send_line(pack_line());
      in_valid = 1'b0;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      fill(50); set_cand(24, 2);
      send_block();
      in_valid = 1'b0;
      wait_out(n);
      chk("t5_idx", 32'(best_idx), 32'(24));
      chk("t5_sad", 32'(best_sad), 32'(72));
      chk("t5_latency", 32'(n), 32'(26));
      @(negedge clk);
      chk("t5_pulses", 32'(ov_count - ov0), 32'(1));
      @(posedge clk); #1;

      // Reset at scan cycle 10 discards the block
      ov0 = ov_count;
      fill(5);
      send_block();
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ready", 32'(in_ready), 32'(1));
      chk("t6_idx", 32'(best_idx), 32'(0));
      chk("t6_sad", 32'(best_sad), 32'(0));
      repeat (40) @(negedge clk);
      chk("t6_no_pulse", 32'(ov_count - ov0), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
